// File: rtl/tone_player_if.sv
// Piezo tone player bus: play request, melody select, speaker and busy.
// The master requests melodies; the slave (player) drives speaker and busy.
interface tone_player_if;
    logic       speakerCall;
    logic [1:0] soundCode;
    logic       speaker;
    logic       busy;

    modport master (
        output speakerCall,
        output soundCode,
        input  speaker,
        input  busy
    );

    modport slave (
        input  speakerCall,
        input  soundCode,
        output speaker,
        output busy
    );
endinterface

// File: rtl/tone_player.sv
// Melody sequencer for a piezo speaker: note ROM, tone and duration timers.
// Optional macro TONE_PLAYER_MUTE_EN adds a mute input that silences speaker.
module tone_player #(
    parameter int TICK_DIV  = 50000,
    parameter int GAP_TICKS = 50
) (
    input  logic clk,
    input  logic reset_n,
`ifdef TONE_PLAYER_MUTE_EN
    input  logic mute,
`endif
    tone_player_if.slave bus
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY,
        GAP
    } state_t;

    state_t        state, stateN;
    logic          callQ;
    logic [1:0]    code, codeN;
    logic [2:0]    idx, idxN;
    logic [16:0]   halfPer, halfN;
    logic [9:0]    durTk, durN;
    logic [16:0]   toneCnt, toneN;
    logic [PW-1:0] preCnt, preN;
    logic [9:0]    tickCnt, tickN;
    logic          spk, spkN;
    logic          req, tick, melodyEnd, ignore;

    // {half-period clocks, duration ticks} for each note of each melody
    function automatic logic [26:0] noteRom(input logic [1:0] c,
                                            input logic [2:0] i);
        logic [26:0] r;
        r = '0;
        case ({c, i})
            5'b00_000, 5'b00_001,
            5'b00_010, 5'b00_101: r = {17'd56818, 10'd500};
            5'b00_011:            r = {17'd71633, 10'd350};
            5'b00_100:            r = {17'd47801, 10'd150};
            5'b01_000:            r = {17'd47801, 10'd30};
            5'b10_000:            r = {17'd37936, 10'd80};
            5'b10_001:            r = {17'd31888, 10'd120};
            default:              r = '0;
        endcase
        return r;
    endfunction

    // index of the final note of a melody
    function automatic logic [2:0] lastIdx(input logic [1:0] c);
        logic [2:0] r;
        case (c)
            2'd0:    r = 3'd5;
            2'd2:    r = 3'd1;
            default: r = 3'd0;
        endcase
        return r;
    endfunction

    // next-state and datapath updates
    always_comb begin
        stateN    = state;
        codeN     = code;
        idxN      = idx;
        halfN     = halfPer;
        durN      = durTk;
        toneN     = toneCnt;
        preN      = preCnt;
        tickN     = tickCnt;
        spkN      = 1'b0;
        melodyEnd = 1'b0;
        req       = (bus.speakerCall != callQ);
        tick      = (preCnt == PW'(TICK_DIV - 1));

        case (state)
            IDLE: begin
                if (req) begin
                    stateN = LOAD;
                    codeN  = bus.soundCode;
                    idxN   = 3'd0;
                end
            end
            LOAD: begin
                {halfN, durN} = noteRom(code, idx);
                toneN  = '0;
                preN   = '0;
                tickN  = '0;
                stateN = (code == 2'd3) ? IDLE : PLAY;
            end
            PLAY: begin
                preN = tick ? '0 : preCnt + PW'(1);
                if (toneCnt == halfPer - 17'd1) begin
                    toneN = '0;
                    spkN  = ~spk;
                end else begin
                    toneN = toneCnt + 17'd1;
                    spkN  = spk;
                end
                if (tick) begin
                    if (tickCnt == durTk - 10'd1) begin
                        tickN = '0;
                        spkN  = 1'b0;
                        if (idx == lastIdx(code)) begin
                            melodyEnd = 1'b1;
                            stateN    = IDLE;
                        end else begin
                            stateN = GAP;
                        end
                    end else begin
                        tickN = tickCnt + 10'd1;
                    end
                end
            end
            GAP: begin
                preN = tick ? '0 : preCnt + PW'(1);
                if (tick) begin
                    if (tickCnt == 10'(GAP_TICKS - 1)) begin
                        tickN  = '0;
                        idxN   = idx + 3'd1;
                        stateN = LOAD;
                    end else begin
                        tickN = tickCnt + 10'd1;
                    end
                end
            end
            default: stateN = IDLE;
        endcase

        // game-over may not be cut short by step/apple, unless it just ended
        ignore = (code == 2'd0)
               && (bus.soundCode == 2'd1 || bus.soundCode == 2'd2)
               && !melodyEnd;

        if (req && state != IDLE && !ignore) begin
            stateN = LOAD;
            codeN  = bus.soundCode;
            idxN   = 3'd0;
            spkN   = 1'b0;
        end
    end

    // state and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            callQ   <= bus.speakerCall;
            code    <= '0;
            idx     <= '0;
            halfPer <= '0;
            durTk   <= '0;
            toneCnt <= '0;
            preCnt  <= '0;
            tickCnt <= '0;
            spk     <= 1'b0;
        end else begin
            state   <= stateN;
            callQ   <= bus.speakerCall;
            code    <= codeN;
            idx     <= idxN;
            halfPer <= halfN;
            durTk   <= durN;
            toneCnt <= toneN;
            preCnt  <= preN;
            tickCnt <= tickN;
            spk     <= spkN;
        end
    end

`ifdef TONE_PLAYER_MUTE_EN
    assign bus.speaker = spk & ~mute;
`else
    assign bus.speaker = spk;
`endif
    assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_tone_player.sv
// Bench for tone_player: run-length scoreboard of {busy, speaker}.
// dutA uses short ticks for sequencing; dutB uses long ticks to see tones.
module tb_tone_player;

    localparam int TDIV   = 10;
    localparam int GAPT   = 2;
    localparam int TDIV_B = 1600;

    logic clk = 1'b0;
    logic rstA_n;
    logic rstB_n;
`ifdef TONE_PLAYER_MUTE_EN
    logic muteA;
    logic muteB;
`endif

    int nChecks = 0;
    int nPass   = 0;

    logic [33:0] qA[$];
    logic [33:0] qB[$];

    tone_player_if busA();
    tone_player_if busB();

    tone_player #(.TICK_DIV(TDIV), .GAP_TICKS(GAPT)) dutA (
        .clk(clk),
        .reset_n(rstA_n),
`ifdef TONE_PLAYER_MUTE_EN
        .mute(muteA),
`endif
        .bus(busA.slave)
    );

    tone_player #(.TICK_DIV(TDIV_B), .GAP_TICKS(GAPT)) dutB (
        .clk(clk),
        .reset_n(rstB_n),
`ifdef TONE_PLAYER_MUTE_EN
        .mute(muteB),
`endif
        .bus(busB.slave)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [33:0] mkRun(input logic b, input logic s,
                                          input int n);
        return {b, s, n};
    endfunction

    // run-length monitors: each finished non-idle run is scored
    logic [1:0] curA = 2'b00;
    logic [1:0] curB = 2'b00;
    logic [1:0] vA, vB;
    int lenA = 0;
    int lenB = 0;
    logic [33:0] eA, eB;

    always @(negedge clk) begin
        vA = {busA.busy, busA.speaker};
        if (vA !== curA && !$isunknown(vA)) begin
            if (curA != 2'b00) begin
                eA = (qA.size() > 0) ? qA.pop_front() : '0;
                checkVal("runA", {curA, lenA}, eA);
            end
            curA = vA;
            lenA = 1;
        end else begin
            lenA++;
        end
    end

    always @(negedge clk) begin
        vB = {busB.busy, busB.speaker};
        if (vB !== curB && !$isunknown(vB)) begin
            if (curB != 2'b00) begin
                eB = (qB.size() > 0) ? qB.pop_front() : '0;
                checkVal("runB", {curB, lenB}, eB);
            end
            curB = vB;
            lenB = 1;
        end else begin
            lenB++;
        end
    end

    task automatic toggleA(input logic [1:0] c);
        @(posedge clk);
        #1;
        busA.soundCode   = c;
        busA.speakerCall = ~busA.speakerCall;
    endtask

    task automatic toggleB(input logic [1:0] c);
        @(posedge clk);
        #1;
        busB.soundCode   = c;
        busB.speakerCall = ~busB.speakerCall;
    endtask

    task automatic waitIdleA();
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while (busA.busy !== 1'b0 && n < 40000) begin
            @(negedge clk);
            n++;
        end
        checkVal("idleA", busA.busy, 0);
        repeat (4) @(posedge clk);
    endtask

    task automatic seqA();
        // step: 1 LOAD + 30 ticks of PLAY
        qA.push_back(mkRun(1, 0, 301));
        toggleA(2'd1);
        @(negedge clk);
        checkVal("busyLat0", busA.busy, 0);
        @(negedge clk);
        checkVal("busyLat1", busA.busy, 1);
        waitIdleA();

        // apple: 1+800+20+1+1200
        qA.push_back(mkRun(1, 0, 2022));
        toggleA(2'd2);
        waitIdleA();

        // game over, step request mid-melody ignored
        qA.push_back(mkRun(1, 0, 25106));
        toggleA(2'd0);
        repeat (999) @(posedge clk);
        toggleA(2'd1);
        waitIdleA();

        // step interrupted by apple after 100 cycles
        qA.push_back(mkRun(1, 0, 100 + 2022));
        toggleA(2'd1);
        repeat (99) @(posedge clk);
        toggleA(2'd2);
        waitIdleA();

        // request on the final PLAY cycle restarts seamlessly
        qA.push_back(mkRun(1, 0, 301 + 301));
        toggleA(2'd1);
        repeat (300) @(posedge clk);
        toggleA(2'd1);
        waitIdleA();

        // silence code: LOAD only
        qA.push_back(mkRun(1, 0, 1));
        toggleA(2'd3);
        waitIdleA();

`ifdef TONE_PLAYER_MUTE_EN
        muteA = 1'b1;
        qA.push_back(mkRun(1, 0, 2022));
        toggleA(2'd2);
        waitIdleA();
        muteA = 1'b0;
`endif

        // reset in the middle of the first apple note
        qA.push_back(mkRun(1, 0, 500));
        toggleA(2'd2);
        repeat (500) @(posedge clk);
        #1 rstA_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkVal("rstBusyA", busA.busy, 0);
        checkVal("rstSpkA", busA.speaker, 0);
        #1;
        busA.speakerCall = ~busA.speakerCall;
        busA.soundCode   = 2'd1;
        repeat (2) @(posedge clk);
        #1 rstA_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkVal("postRstIdle", busA.busy, 0);
        end
    endtask

    task automatic seqB();
        // step at long ticks: 47801 cycles of PLAY before first rise
        qB.push_back(mkRun(1, 0, 47802));
`ifdef TONE_PLAYER_MUTE_EN
        qB.push_back(mkRun(1, 1, 50));
        qB.push_back(mkRun(1, 0, 50));
        qB.push_back(mkRun(1, 1, 99));
`else
        qB.push_back(mkRun(1, 1, 199));
`endif
        toggleB(2'd1);
        repeat (47853) @(posedge clk);
`ifdef TONE_PLAYER_MUTE_EN
        #1 muteB = 1'b1;
        repeat (50) @(posedge clk);
        #1 muteB = 1'b0;
`endif
        repeat (200) @(posedge clk);
        @(negedge clk);
        checkVal("idleB", busB.busy, 0);
        checkVal("spkB", busB.speaker, 0);
    endtask

    initial begin
        rstA_n = 1'b0;
        rstB_n = 1'b0;
        busA.speakerCall = 1'b0;
        busA.soundCode   = 2'd0;
        busB.speakerCall = 1'b0;
        busB.soundCode   = 2'd0;
`ifdef TONE_PLAYER_MUTE_EN
        muteA = 1'b0;
        muteB = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkVal("rstBusy", busA.busy, 0);
        checkVal("rstSpk", busA.speaker, 0);
        checkVal("rstBusyB", busB.busy, 0);
        #1;
        rstA_n = 1'b1;
        rstB_n = 1'b1;

        fork
            seqA();
            seqB();
        join

        repeat (5) @(posedge clk);
        checkVal("sbA empty", qA.size(), 0);
        checkVal("sbB empty", qB.size(), 0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/tone_player.md
TONE_PLAYER -- requirements
Module: tone_player

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, meaning clk cycles per duration tick (1 ms at 50 MHz).
REQ-002 SHALL have parameter GAP_TICKS, default 50, meaning the silent ticks inserted between consecutive notes of one melody.
REQ-003 SHALL have port clk  input  1  system clock (50 MHz); all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port speakerCall  input  1  play request; every level change (toggle) is one request.
REQ-006 SHALL have port soundCode  input  2  melody selector, sampled in the cycle a toggle is detected.
REQ-007 SHALL have port speaker  output  1  square-wave drive to the piezo.
REQ-008 SHALL have port busy  output  1  high while a melody is in LOAD, PLAY or GAP.

Function
REQ-009 SHALL register speakerCall every cycle into call_q; a request SHALL be detected in any cycle where speakerCall != call_q.
REQ-010 SHALL implement states IDLE, LOAD, PLAY, GAP.
REQ-011 SHALL move from IDLE to LOAD on a request, latching soundCode and clearing note index to 0.
REQ-012 SHALL, in LOAD, read the note ROM entry (half-period count, duration ticks) for (code, index), reset the tone and tick counters, and enter PLAY the following cycle.
REQ-013 SHALL use ROM code 0 (game over): 56818/500, 56818/500, 56818/500, 71633/350, 47801/150, 56818/500 (half-period clocks / ticks).
REQ-014 SHALL use ROM code 1 (step): 47801/30, single note.
REQ-015 SHALL use ROM code 2 (apple): 37936/80, 31888/120.
REQ-016 SHALL treat code 3 as silence: LOAD returns to IDLE without entering PLAY, speaker remaining 0.
REQ-017 SHALL, in PLAY, invert speaker each time the tone counter reaches half-period-1; first inversion occurs half-period cycles after entering PLAY.
REQ-018 SHALL count duration ticks with a TICK_DIV prescaler; on the last tick of a note, it SHALL enter GAP if more notes remain, else IDLE.
REQ-019 SHALL hold speaker at 0 in IDLE, LOAD and GAP.
REQ-020 SHALL, after GAP_TICKS ticks in GAP, increment note index and enter LOAD.
REQ-021 SHALL, on a request during LOAD/PLAY/GAP, restart at LOAD with the new code and index 0, except when the latched code is 0 and the new code is 1 or 2, which SHALL be ignored.
REQ-022 SHALL treat a request coinciding with melody end as a fresh request (LOAD next cycle).
REQ-023 SHALL size tone counter 17 bits and duration counter 10 bits; no counter SHALL wrap during legal operation.
REQ-024 SHALL drive busy combinationally from state (busy = state != IDLE).

Reset
REQ-025 SHALL, while reset_n is 0 at a clock edge, set state IDLE, speaker 0, busy 0, all counters and index 0, and call_q = speakerCall (no request detected on reset release).
REQ-026 SHALL abort any melody on reset mid-operation; speaker SHALL be 0 from the first clock edge with reset_n low.

Configuration
REQ-027 SHALL, with TONE_PLAYER_MUTE_EN defined, add input port mute (1 bit); while mute is 1 speaker SHALL be 0 but sequencing, timing and busy SHALL be unchanged.
REQ-028 SHALL, without TONE_PLAYER_MUTE_EN, have no mute port and behave as REQ-009..REQ-024.

Verification (TICK_DIV=10, GAP_TICKS=2 for bench)
REQ-029 SHALL cover: reset, toggle speakerCall with code 1 -> busy high one cycle later, speaker first rises 47801 cycles after PLAY entry, busy low after 300 cycles of PLAY.
REQ-030 SHALL cover: code 2 request -> 800-cycle E5 note, 20-cycle silent gap, 1200-cycle G5 note, then IDLE.
REQ-031 SHALL cover: code 0 playing, toggle with code 1 -> ignored, melody completes all 6 notes; toggle with code 2 during code 1 -> restarts apple melody at note 0.
REQ-032 SHALL cover: code 3 request -> busy high for exactly LOAD cycle, speaker stays 0.
REQ-033 SHALL cover: reset_n low mid-PLAY -> speaker 0 and busy 0 next edge; release with speakerCall unchanged -> stays IDLE.
REQ-034 SHALL cover (TONE_PLAYER_MUTE_EN): mute=1 during code 2 -> speaker 0 throughout, busy timing identical to unmuted run.
